// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core: mult/div opcodes, mult/div FSM states, default width.
package mips_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Magnitude extraction on entry and sign restoration on exit for signed MULT/DIV.
// Exists only when MULDIV_SIGNED_EN is defined.
`ifdef MULDIV_SIGNED_EN
module muldiv_sign_adjust
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             i_signed,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_mag_a,
    output logic [WIDTH-1:0] o_mag_b,
    output logic             o_neg_res,
    output logic             o_neg_rem,
    input  logic             i_fix_div,
    input  logic             i_fix_res,
    input  logic             i_fix_rem,
    input  logic [WIDTH-1:0] i_raw_hi,
    input  logic [WIDTH-1:0] i_raw_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic             w_a_neg;
    logic             w_b_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_a_neg   = i_signed & i_a[WIDTH-1];
    assign w_b_neg   = i_signed & i_b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign o_mag_a   = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign o_mag_b   = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign o_neg_res = w_a_neg ^ w_b_neg;
    assign o_neg_rem = i_is_div & w_a_neg;

    assign w_prod     = {i_raw_hi, i_raw_lo};
    assign w_prod_neg = ~w_prod + 1'b1;

    always_comb begin
        o_hi = i_raw_hi;
        o_lo = i_raw_lo;
        if (i_fix_div) begin
            if (i_fix_rem) o_hi = ~i_raw_hi + 1'b1;
            if (i_fix_res) o_lo = ~i_raw_lo + 1'b1;
        end else if (i_fix_res) begin
            {o_hi, o_lo} = w_prod_neg;
        end
    end

endmodule
`endif

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers; one shift-add/restoring step per cycle.
// Signed MULT/DIV handling is built only when MULDIV_SIGNED_EN is defined.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_hi_write,
    input  logic             i_lo_write,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    muldiv_state_e      r_state, w_state_nxt;
    logic [CW-1:0]      r_count, w_count_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_m, w_m_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;
    logic               r_dbz, w_dbz_nxt;

    logic               w_start_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_start_div = (i_op == OP_DIV) || (i_op == OP_DIVU);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m & {WIDTH{r_acc[0]}}};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign w_rem      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem - {1'b0, r_m};
    assign w_div_next = w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_step = r_is_div ? w_div_next : w_mul_next;

`ifdef MULDIV_SIGNED_EN
    logic r_neg_res, w_neg_res_nxt;
    logic r_neg_rem, w_neg_rem_nxt;
    logic w_signed;
    logic w_neg_res;
    logic w_neg_rem;

    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);

    muldiv_sign_adjust #(
        .WIDTH (WIDTH)
    ) u_sign_adjust (
        .i_signed  (w_signed),
        .i_is_div  (w_start_div),
        .i_a       (i_operand_a),
        .i_b       (i_operand_b),
        .o_mag_a   (w_mag_a),
        .o_mag_b   (w_mag_b),
        .o_neg_res (w_neg_res),
        .o_neg_rem (w_neg_rem),
        .i_fix_div (r_is_div),
        .i_fix_res (r_neg_res),
        .i_fix_rem (r_neg_rem),
        .i_raw_hi  (w_step[2*WIDTH-1:WIDTH]),
        .i_raw_lo  (w_step[WIDTH-1:0]),
        .o_hi      (w_res_hi),
        .o_lo      (w_res_lo)
    );

    always_comb begin
        w_neg_res_nxt = r_neg_res;
        w_neg_rem_nxt = r_neg_rem;
        if (i_start && (r_state != ST_RUN)) begin
            w_neg_res_nxt = w_neg_res;
            w_neg_rem_nxt = w_neg_rem;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            r_neg_res <= w_neg_res_nxt;
            r_neg_rem <= w_neg_rem_nxt;
        end
    end
`else
    assign w_mag_a  = i_operand_a;
    assign w_mag_b  = i_operand_b;
    assign w_res_hi = w_step[2*WIDTH-1:WIDTH];
    assign w_res_lo = w_step[WIDTH-1:0];
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_is_div_nxt = r_is_div;
        w_acc_nxt    = r_acc;
        w_m_nxt      = r_m;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_dbz_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (i_start) begin
                    if (w_start_div && (i_operand_b == '0)) begin
                        w_state_nxt = ST_DONE;
                        w_hi_nxt    = i_operand_a;
                        w_lo_nxt    = '1;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RUN;
                        w_count_nxt  = CW'(WIDTH);
                        w_is_div_nxt = w_start_div;
                        w_acc_nxt    = {{WIDTH{1'b0}}, w_start_div ? w_mag_a : w_mag_b};
                        w_m_nxt      = w_start_div ? w_mag_b : w_mag_a;
                    end
                end else begin
                    if (i_hi_write) w_hi_nxt = i_operand_a;
                    if (i_lo_write) w_lo_nxt = i_operand_a;
                end
            end
            ST_RUN: begin
                w_acc_nxt   = w_step;
                w_count_nxt = r_count - 1'b1;
                if (r_count == CW'(1)) begin
                    w_state_nxt = ST_DONE;
                    w_hi_nxt    = w_res_hi;
                    w_lo_nxt    = w_res_lo;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_is_div <= w_is_div_nxt;
            r_acc    <= w_acc_nxt;
            r_m      <= w_m_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign o_busy        = (r_state == ST_RUN);
    assign o_done        = (r_state == ST_DONE);
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand-written corner sequences.
// Expected values follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_mult_div_unit;
    import mips_pkg::*;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_hi_write;
    logic        i_lo_write;
    logic        o_busy;
    logic        o_done;
    logic        o_dbz;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int          n_checks = 0;
    int          n_fails  = 0;
    exp_t        sb[$];
    vec_t        vecs[12];
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_operand_a   (i_a),
        .i_operand_b   (i_b),
        .i_hi_write    (i_hi_write),
        .i_lo_write    (i_lo_write),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_dbz),
        .o_hi          (o_hi),
        .o_lo          (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: every Done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", o_done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", o_hi, e.hi);
                check("result_lo", o_lo, e.lo);
                check("result_dbz", o_dbz, e.dbz);
            end
        end
    end

    // Called and returns at a negedge; returns on the Done cycle.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic edbz,
                          input bit poke, input bit lo_wr);
        int cyc;
        int busy_cnt;
        i_start    = 1'b1;
        i_op       = op;
        i_a        = a;
        i_b        = b;
        i_lo_write = lo_wr;
        sb.push_back('{eh, el, edbz});
        @(negedge clk);
        i_start    = 1'b0;
        i_lo_write = 1'b0;
        if (lo_wr) check("lo_write_dropped", o_lo, cur_lo);
        cyc      = 0;
        busy_cnt = 0;
        while (!o_done && cyc < 200) begin
            if (o_busy) busy_cnt++;
            if (cyc == 5) begin
                check("hold_hi_in_run", o_hi, cur_hi);
                check("hold_lo_in_run", o_lo, cur_lo);
            end
            if (poke && cyc == 4) begin
                i_start    = 1'b1;
                i_hi_write = 1'b1;
                i_op       = OP_DIVU;
                i_a        = 32'hDEADBEEF;
                i_b        = 32'h1;
            end else begin
                i_start    = 1'b0;
                i_hi_write = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        check("done_seen", o_done, 1'b1);
        check("busy_cycles", busy_cnt, edbz ? 0 : 32);
        check("busy_at_done", o_busy, 1'b0);
        cur_hi = eh;
        cur_lo = el;
    endtask

    task automatic finish_idle();
        @(negedge clk);
        check("done_one_cycle", o_done, 1'b0);
        check("dbz_one_cycle", o_dbz, 1'b0);
        check("idle_not_busy", o_busy, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT, 32'hFFFFFFFD, 32'h7, SIGNED_EN ? 32'hFFFFFFFF : 32'h6,
                     32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_DIV, 32'hFFFFFFF9, 32'h2, SIGNED_EN ? 32'hFFFFFFFF : 32'h1,
                     SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0};
        vecs[3]  = '{OP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0};
        vecs[4]  = '{OP_DIVU, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, SIGNED_EN ? 32'h0 : 32'h80000000,
                     SIGNED_EN ? 32'h80000000 : 32'h0, 1'b0};
        vecs[6]  = '{OP_MULT, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[7]  = '{OP_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0};
        vecs[8]  = '{OP_MULTU, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0};
        vecs[9]  = '{OP_DIV, 32'd7, 32'hFFFFFFFE, SIGNED_EN ? 32'h1 : 32'h7,
                     SIGNED_EN ? 32'hFFFFFFFD : 32'h0, 1'b0};
        vecs[10] = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0};
        vecs[11] = '{OP_DIV, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1};

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_op       = OP_MULT;
        i_a        = '0;
        i_b        = '0;
        i_hi_write = 1'b0;
        i_lo_write = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", o_busy, 1'b0);
        check("reset_done", o_done, 1'b0);
        check("reset_dbz", o_dbz, 1'b0);
        check("reset_hi", o_hi, 32'h0);
        check("reset_lo", o_lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                   1'b0, 1'b0);
            finish_idle();
        end

        // Start and MTHI while busy must both be ignored.
        launch(OP_MULTU, 32'd3, 32'd5, 32'h0, 32'hF, 1'b0, 1'b1, 1'b0);
        finish_idle();

        i_hi_write = 1'b1;
        i_a        = 32'h1234;
        @(negedge clk);
        i_hi_write = 1'b0;
        check("mthi_hi", o_hi, 32'h1234);
        check("mthi_lo_kept", o_lo, cur_lo);
        cur_hi = 32'h1234;

        i_hi_write = 1'b1;
        i_lo_write = 1'b1;
        i_a        = 32'hCAFEF00D;
        @(negedge clk);
        i_hi_write = 1'b0;
        i_lo_write = 1'b0;
        check("mthi_mtlo_hi", o_hi, 32'hCAFEF00D);
        check("mthi_mtlo_lo", o_lo, 32'hCAFEF00D);
        cur_hi = 32'hCAFEF00D;
        cur_lo = 32'hCAFEF00D;

        launch(OP_MULTU, 32'hAAAA5555, 32'd2, 32'h1, 32'h5554AAAA, 1'b0, 1'b0, 1'b1);
        finish_idle();

        // Back-to-back launches from the Done cycle, including a divide-by-zero.
        launch(OP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 1'b0, 1'b0);
        launch(OP_MULTU, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1'b0, 1'b0);
        launch(OP_DIVU, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        finish_idle();

        // Reset in the middle of a divide discards it.
        i_start = 1'b1;
        i_op    = OP_DIV;
        i_a     = 32'd100;
        i_b     = 32'd7;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", o_busy, 1'b0);
        check("midreset_done", o_done, 1'b0);
        check("midreset_hi", o_hi, 32'h0);
        check("midreset_lo", o_lo, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        launch(OP_MULTU, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1'b0, 1'b0);
        finish_idle();

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. Consumes the two register-file read operands (rs, rt) on MULT/MULTU/DIV/DIVU, runs a WIDTH-cycle shift-add or restoring-divide loop, and holds the result in HI/LO. The core stalls on Busy, and MFHI/MFLO read Hi/Lo back into the register-file write path.

## Interface
- WIDTH, 32: operand width; also the iteration count.
- Clock  in  1  system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  launch operation; sampled only when Busy=0.
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Operand_A  in  WIDTH  rs value: multiplicand or dividend.
- Operand_B  in  WIDTH  rt value: multiplier or divisor.
- Hi_Write  in  1  MTHI: load Operand_A into Hi.
- Lo_Write  in  1  MTLO: load Operand_A into Lo.
- Busy  out  1  operation in progress; core must stall.
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result.
- Div_By_Zero  out  1  pulses with Done when a DIV/DIVU had Operand_B=0.
- Hi  out  WIDTH  HI register (product high half / remainder).
- Lo  out  WIDTH  LO register (product low half / quotient).

## Operation
- Reset (Reset_n=0, any time, including mid-operation): state IDLE, counter 0, Busy=0, Done=0, Div_By_Zero=0, Hi=0, Lo=0. The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with Start=1: latch Op and operands, go to RUN, counter=WIDTH.
  - Exception: DIV/DIVU with Operand_B=0 goes straight to DONE and sets Hi=Operand_A, Lo=all ones, Div_By_Zero=1.
  - RUN: one iteration per cycle, counter decrements. At counter=1 the edge applies the sign fix, writes Hi/Lo, and enters DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE unless Start.
- Multiply: unsigned shift-add over the magnitudes; 2*WIDTH-bit product; Hi=upper WIDTH bits, Lo=lower WIDTH bits.
- Divide: restoring division over the magnitudes.
- Signed ops (MULT/DIV):
  - Operate on absolute values.
  - Negate the product if the operand signs differ.
  - Negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Most-negative / -1 gives Lo=0x80000000, Hi=0 (wraps, no trap).
- Start while Busy=1: ignored; the operation in progress is unaffected.
- Hi_Write/Lo_Write:
  - Honoured only when Busy=0 and Start=0.
  - If Start=1 in the same cycle, Start wins and the writes are dropped.
  - Ignored while Busy.
  - Hi_Write and Lo_Write together are legal; both registers load Operand_A.
- Hi/Lo are unchanged during RUN; the previous values stay visible until the result edge.

## Timing
- Start sampled at edge 0:
  - Busy=1 after edges 0..WIDTH-1 (WIDTH cycles).
  - After edge WIDTH: Busy=0, Done=1, Hi/Lo valid.
  - After edge WIDTH+1: Done=0.
- Divide by zero: Done and Div_By_Zero are 1 after edge 0. Busy is never asserted.
- Back-to-back: Start in the DONE cycle launches the next operation with no idle gap.
- Hi/Lo outputs come directly from registers, with no combinational path from the inputs. The register file captures MFHI/MFLO data at the following negedge.

## Configuration
- MULDIV_SIGNED_EN defined: MULT/DIV perform the signed handling described above.
- Not defined:
  - Op[0] is ignored and every operation is unsigned; MULT behaves as MULTU, DIV as DIVU.
  - No sign-fix logic is synthesized.
  - Timing is identical.

## Structure
- Shared package mips_pkg holds:
  - the Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - the WIDTH default.
- One sub-module, muldiv_sign_adjust: combinational absolute-value on entry plus conditional negation of result/remainder on exit. It is present only under MULDIV_SIGNED_EN.
- The control FSM, counter and shared partial-remainder/product register stay in mult_div_unit.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy for 32 cycles, Done on cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007) -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Without MULDIV_SIGNED_EN: Hi=0x00000006, Lo=0xFFFFFFEB.
- DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100 / 7 -> Lo=0x0000000E, Hi=0x00000002.
- DIVU 0x64 / 0 -> Done and Div_By_Zero one cycle after Start, Busy never 1, Hi=0x00000064, Lo=0xFFFFFFFF.
- Start a MULTU, then:
  - pulse Start with new operands and Hi_Write at cycle 5 -> both ignored, original result delivered at cycle 33;
  - MTHI 0x1234 while idle -> Hi=0x00001234;
  - Start+Lo_Write same cycle -> Lo_Write dropped.
- Reset_n low at cycle 10 of a DIV -> immediately Busy=0, Done=0, Hi=Lo=0. After release, a new MULTU 2x3 -> Lo=6, Hi=0.
